// File: rtl/sect_pt_check.sv
// sect_pt_check: validates an affine point (x, y) against the binary curve
//   y^2 + x*y = x^3 + A*x^2 + B over F_2^M, reduced by f(x) = x^M + FX.
// Sits downstream of the point multiplier; start comes from its done pulse.
// One shared segmented multiplier is sequenced by an FSM; squares are combinational.
//
// Ports:
//   clk    in   system clock
//   rst_n  in   asynchronous reset, active low
//   clr    in   synchronous clear, aborts any check in flight
//   start  in   one-cycle request, x/y sampled in the same cycle (accepted only when idle)
//   x, y   in   affine coordinates, M bits, assumed reduced
//   busy   out  check in progress
//   done   out  level, result available; cleared by clr or an accepted start
//   valid  out  point lies on the curve (meaningful while done)
//   ybit   out  compressed-point bit lsb(y/x); 0 when x == 0 or compression disabled
//
// Build option: define SECT_PT_CHECK_COMPRESS_EN to also compute ybit. This adds a
// Fermat inverter (INV state, M+2 cycles) and a third multiply (MUL3) when x != 0.

module sect_pt_check #(
    parameter int unsigned  M             = 163,
    parameter logic [M-1:0] FX            = M'(8'hc9),
    parameter logic [M-1:0] A             = M'(1'b1),
    parameter logic [M-1:0] B             = M'(1'b1),
    parameter int unsigned  NUM_CYCLE_MUL = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         start,
    input  logic [M-1:0] x,
    input  logic [M-1:0] y,
    output logic         busy,
    output logic         done,
    output logic         valid,
    output logic         ybit
);

    // Multiplier consumes Seg bits of the b operand per cycle, MSB first.
    localparam int unsigned Seg     = (M + NUM_CYCLE_MUL - 1) / NUM_CYCLE_MUL;
    localparam int unsigned Bw      = Seg * NUM_CYCLE_MUL;
    localparam int unsigned CntW    = $clog2(M + 2);
    localparam int unsigned SegCntW = $clog2(NUM_CYCLE_MUL + 1);
    localparam int unsigned MulLast = NUM_CYCLE_MUL + 1;

    typedef enum logic [2:0] {
        StIdle,
        StMul1,
        StMul2,
`ifdef SECT_PT_CHECK_COMPRESS_EN
        StInv,
        StMul3,
`endif
        StCmp
    } state_e;

    // Multiply by the polynomial x, reducing modulo f.
    function automatic logic [M-1:0] xtimes(input logic [M-1:0] v);
        return {v[M-2:0], 1'b0} ^ (v[M-1] ? FX : '0);
    endfunction

    // Squaring is linear in F_2^M: spread bits to even positions, then reduce top-down.
    function automatic logic [M-1:0] gf_sqr(input logic [M-1:0] v);
        logic [2*M-2:0] p;
        p = '0;
        for (int i = 0; i < M; i++) begin
            p[2*i] = v[i];
        end
        for (int i = 2 * M - 2; i >= int'(M); i--) begin
            if (p[i]) begin
                p[i-M +: M] = p[i-M +: M] ^ FX;
            end
        end
        return p[M-1:0];
    endfunction

    // One multiplier segment: Horner steps over the next Seg bits of b.
    function automatic logic [M-1:0] mul_seg(input logic [M-1:0]   acc_in,
                                             input logic [M-1:0]   a,
                                             input logic [Seg-1:0] bits);
        logic [M-1:0] acc;
        acc = acc_in;
        for (int i = Seg - 1; i >= 0; i--) begin
            acc = xtimes(acc) ^ (bits[i] ? a : '0);
        end
        return acc;
    endfunction

`ifdef SECT_PT_CHECK_COMPRESS_EN
    function automatic logic [M-1:0] gf_mul(input logic [M-1:0] a, input logic [M-1:0] b);
        logic [M-1:0] acc;
        acc = '0;
        for (int i = M - 1; i >= 0; i--) begin
            acc = xtimes(acc) ^ (b[i] ? a : '0);
        end
        return acc;
    endfunction
`endif

    // State and datapath registers
    state_e             state_q, state_d;
    logic [CntW-1:0]    cnt_q, cnt_d;
    logic [M-1:0]       x_q, x_d;
    logic [M-1:0]       y_q, y_d;
    logic [M-1:0]       t1_q, t1_d;
    logic [M-1:0]       t2_q, t2_d;
    logic               done_q, done_d;
    logic               valid_q, valid_d;

    // Shared multiplier
    logic [M-1:0]       mul_a_q, mul_a_d;
    logic [Bw-1:0]      mul_b_q, mul_b_d;
    logic [M-1:0]       mul_acc_q, mul_acc_d;
    logic [SegCntW-1:0] mul_seg_q, mul_seg_d;

`ifdef SECT_PT_CHECK_COMPRESS_EN
    logic [M-1:0]       t3_q, t3_d;
    logic [M-1:0]       inv_a_q, inv_a_d;
    logic [M-1:0]       inv_b_q, inv_b_d;
    logic [CntW-1:0]    inv_cnt_q, inv_cnt_d;
    logic               ybit_q, ybit_d;
    logic               inv_start;
    logic               inv_last;
`endif

    logic               mul_start;
    logic               mul_last;
    logic               accept;
    logic [M-1:0]       mul_op_a;
    logic [M-1:0]       mul_op_b;

    //--------------------------------------------------------------------------------------
    // FSM: state register
    //--------------------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    //--------------------------------------------------------------------------------------
    // FSM: next state
    //--------------------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (start) state_d = StMul1;
            StMul1: if (mul_last) state_d = StMul2;
`ifdef SECT_PT_CHECK_COMPRESS_EN
            // x == 0 has no inverse; ybit is defined as 0 there, so skip straight to compare.
            StMul2: if (mul_last) state_d = (x_q != '0) ? StInv : StCmp;
            StInv:  if (inv_last) state_d = StMul3;
            StMul3: if (mul_last) state_d = StCmp;
`else
            StMul2: if (mul_last) state_d = StCmp;
`endif
            StCmp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
        if (clr) begin
            state_d = StIdle;
        end
    end

    //--------------------------------------------------------------------------------------
    // FSM: outputs and multiplier operand selection
    //--------------------------------------------------------------------------------------
    always_comb begin
        busy      = (state_q != StIdle);
        accept    = (state_q == StIdle) && start;
        mul_last  = (cnt_q == CntW'(MulLast));
        mul_start = 1'b0;
        mul_op_a  = '0;
        mul_op_b  = '0;
`ifdef SECT_PT_CHECK_COMPRESS_EN
        inv_start = (state_q == StInv) && (cnt_q == '0);
        inv_last  = (cnt_q == CntW'(M + 1));
`endif
        unique case (state_q)
            StMul1: begin
                mul_start = (cnt_q == '0);
                mul_op_a  = x_q;
                mul_op_b  = y_q;
            end
            StMul2: begin
                mul_start = (cnt_q == '0);
                mul_op_a  = gf_sqr(x_q);
                mul_op_b  = x_q ^ A;
            end
`ifdef SECT_PT_CHECK_COMPRESS_EN
            StMul3: begin
                mul_start = (cnt_q == '0);
                mul_op_a  = y_q;
                mul_op_b  = t3_q;
            end
`endif
            default: ;
        endcase
    end

    //--------------------------------------------------------------------------------------
    // Datapath next state
    //--------------------------------------------------------------------------------------
    always_comb begin
        cnt_d     = '0;
        x_d       = x_q;
        y_d       = y_q;
        t1_d      = t1_q;
        t2_d      = t2_q;
        done_d    = done_q;
        valid_d   = valid_q;
        mul_a_d   = mul_a_q;
        mul_b_d   = mul_b_q;
        mul_acc_d = mul_acc_q;
        mul_seg_d = mul_seg_q;
`ifdef SECT_PT_CHECK_COMPRESS_EN
        t3_d      = t3_q;
        inv_a_d   = inv_a_q;
        inv_b_d   = inv_b_q;
        inv_cnt_d = inv_cnt_q;
        ybit_d    = ybit_q;
`endif

        // Phase counter and result capture
        unique case (state_q)
            StMul1: begin
                cnt_d = mul_last ? '0 : cnt_q + CntW'(1);
                if (mul_last) t1_d = mul_acc_q;
            end
            StMul2: begin
                cnt_d = mul_last ? '0 : cnt_q + CntW'(1);
                if (mul_last) t2_d = mul_acc_q;
            end
`ifdef SECT_PT_CHECK_COMPRESS_EN
            StInv: begin
                cnt_d = inv_last ? '0 : cnt_q + CntW'(1);
                if (inv_last) t3_d = inv_b_q;
            end
            StMul3: begin
                cnt_d = mul_last ? '0 : cnt_q + CntW'(1);
                if (mul_last) t3_d = mul_acc_q;
            end
`endif
            StCmp: begin
                valid_d = ((gf_sqr(y_q) ^ t1_q) == (t2_q ^ B));
                done_d  = 1'b1;
`ifdef SECT_PT_CHECK_COMPRESS_EN
                ybit_d  = (x_q != '0) ? t3_q[0] : 1'b0;
`endif
            end
            default: ;
        endcase

        if (accept) begin
            x_d     = x;
            y_d     = y;
            done_d  = 1'b0;
            valid_d = 1'b0;
`ifdef SECT_PT_CHECK_COMPRESS_EN
            ybit_d  = 1'b0;
`endif
        end

        // Segmented multiplier: load on start, then NUM_CYCLE_MUL segment steps.
        if (mul_start) begin
            mul_a_d   = mul_op_a;
            mul_b_d   = Bw'(mul_op_b);
            mul_acc_d = '0;
            mul_seg_d = SegCntW'(NUM_CYCLE_MUL);
        end else if (mul_seg_q != '0) begin
            mul_acc_d = mul_seg(mul_acc_q, mul_a_q, mul_b_q[Bw-1 -: Seg]);
            mul_b_d   = mul_b_q << Seg;
            mul_seg_d = mul_seg_q - SegCntW'(1);
        end

`ifdef SECT_PT_CHECK_COMPRESS_EN
        // Fermat inverse x^(2^M-2): M-2 steps of b <= b^2 * a, then one final squaring.
        if (inv_start) begin
            inv_a_d   = x_q;
            inv_b_d   = x_q;
            inv_cnt_d = CntW'(M - 1);
        end else if (inv_cnt_q != '0) begin
            inv_b_d   = (inv_cnt_q == CntW'(1)) ? gf_sqr(inv_b_q)
                                                 : gf_mul(gf_sqr(inv_b_q), inv_a_q);
            inv_cnt_d = inv_cnt_q - CntW'(1);
        end
`endif

        if (clr) begin
            cnt_d     = '0;
            done_d    = 1'b0;
            valid_d   = 1'b0;
            mul_seg_d = '0;
`ifdef SECT_PT_CHECK_COMPRESS_EN
            ybit_d    = 1'b0;
            inv_cnt_d = '0;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            x_q       <= '0;
            y_q       <= '0;
            t1_q      <= '0;
            t2_q      <= '0;
            done_q    <= 1'b0;
            valid_q   <= 1'b0;
            mul_a_q   <= '0;
            mul_b_q   <= '0;
            mul_acc_q <= '0;
            mul_seg_q <= '0;
`ifdef SECT_PT_CHECK_COMPRESS_EN
            t3_q      <= '0;
            inv_a_q   <= '0;
            inv_b_q   <= '0;
            inv_cnt_q <= '0;
            ybit_q    <= 1'b0;
`endif
        end else begin
            cnt_q     <= cnt_d;
            x_q       <= x_d;
            y_q       <= y_d;
            t1_q      <= t1_d;
            t2_q      <= t2_d;
            done_q    <= done_d;
            valid_q   <= valid_d;
            mul_a_q   <= mul_a_d;
            mul_b_q   <= mul_b_d;
            mul_acc_q <= mul_acc_d;
            mul_seg_q <= mul_seg_d;
`ifdef SECT_PT_CHECK_COMPRESS_EN
            t3_q      <= t3_d;
            inv_a_q   <= inv_a_d;
            inv_b_q   <= inv_b_d;
            inv_cnt_q <= inv_cnt_d;
            ybit_q    <= ybit_d;
`endif
        end
    end

    assign done  = done_q;
    assign valid = valid_q;
`ifdef SECT_PT_CHECK_COMPRESS_EN
    assign ybit  = ybit_q;
`else
    assign ybit  = 1'b0;
`endif

endmodule
